// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop computes a - b - bin LSB-first.
// Latency: a start accepted at edge E0 raises done for the cycle after edge E0+WIDTH; back-to-back rate is WIDTH+1 cycles.
// Backpressure: none; start is sampled only in IDLE/DONE and ignored while busy. diff/bout hold until the next completion.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             operation request (accepted in IDLE or DONE)
//   a, b, bin         minuend, subtrahend, borrow-in (captured on the accepted start edge)
//   busy              high while bits are being processed (RUN)
//   done              one-cycle pulse when diff/bout are updated
//   diff, bout        registered difference and MSB borrow-out
//   ovf               signed overflow of a - b - bin (only with SERIAL_SUBTRACTOR_OVF_EN defined)
//
// Optional build macro: SERIAL_SUBTRACTOR_OVF_EN adds the ovf output and its flop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Only WIDTH-1 partial bits are ever stored; the MSB is produced on the
    // final edge and goes straight into diff.
    logic [WIDTH-2:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Full-subtractor cell on the current LSBs
    logic             a_bit, b_bit, d_bit, br_nxt, last_bit;
    logic [WIDTH-1:0] res_sh;

    assign a_bit    = a_sh_q[0];
    assign b_bit    = b_sh_q[0];
    assign d_bit    = a_bit ^ b_bit ^ br_q;
    assign br_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    // New bit enters from the MSB side; on the last edge this is the full result.
    assign res_sh   = {d_bit, res_q};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = bin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_sh[WIDTH-1:1];
                br_d   = br_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (last_bit) begin
                    state_d = DONE;
                    diff_d  = res_sh;
                    bout_d  = br_nxt;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    // br_q is the borrow into the MSB cell on this edge.
                    ovf_d   = br_q ^ br_nxt;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): reset, arithmetic corners,
// back-to-back operation, start/input isolation during RUN, reset abort.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [WIDTH-1:0] prev_diff;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One complete operation; optionally pulses start and scrambles operands mid-RUN.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic tbin, input logic [WIDTH-1:0] ed,
                          input logic eb, input logic eo, input bit disturb,
                          input string tag);
        @(negedge clk);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= WIDTH; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                chk({tag, "_diff_held"}, 32'(diff), 32'(prev_diff));
            end
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            if (disturb && i == 3) begin
                start = 1'b1; a = ~ta; b = ~tb_v; bin = ~tbin;
            end
            if (disturb && i == 4) start = 1'b0;
        end
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo) begin end
`endif
        prev_diff = ed;
        @(negedge clk);
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        prev_diff = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif

        // 100 - 37 = 63
        run_op(8'd100, 8'd37, 1'b0, 8'd63, 1'b0, 1'b0, 1'b0, "op100_37");
        // 0 - 1 wraps to all-ones with borrow
        run_op(8'd0, 8'd1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, "op0_1");
        // equal operands with borrow-in
        run_op(8'd5, 8'd5, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "op5_5_bin");

        // Back-to-back: 200-55=145, then 10-20 = 246 with borrow, no IDLE gap
        @(negedge clk);
        a = 8'd200; b = 8'd55; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= WIDTH; i++) begin
            @(negedge clk);
            chk("b2b1_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("b2b1_done", 32'(done), 32'd1);
        chk("b2b1_diff", 32'(diff), 32'd145);
        chk("b2b1_bout", 32'(bout), 32'd0);
        a = 8'd10; b = 8'd20;
        @(negedge clk);
        chk("b2b2_run_busy", 32'(busy), 32'd1);
        chk("b2b2_run_nodone", 32'(done), 32'd0);
        chk("b2b2_diff_held", 32'(diff), 32'd145);
        start = 1'b0;
        for (int i = 2; i <= WIDTH; i++) begin
            @(negedge clk);
            chk("b2b2_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("b2b2_done", 32'(done), 32'd1);
        chk("b2b2_diff", 32'(diff), 32'd246);
        chk("b2b2_bout", 32'(bout), 32'd1);
        prev_diff = 8'd246;
        @(negedge clk);
        chk("b2b2_idle", 32'(done), 32'd0);

        // start pulse and operand changes during RUN must not disturb: 60 - 15 = 45
        run_op(8'd60, 8'd15, 1'b0, 8'd45, 1'b0, 1'b0, 1'b1, "isolate");

        // Reset in RUN cycle 4 aborts: no done, outputs back to reset values
        @(negedge clk);
        a = 8'd9; b = 8'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            chk("abort_busy", 32'(busy), 32'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy_off", 32'(busy), 32'd0);
        chk("abort_done_off", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
        end
        prev_diff = '0;

        // Signed overflow corners (ovf checked only when the port exists)
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, "op80_01");
        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "op05_03");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
